cycle_monitor: RTL and testbench

CYCLE_MONITOR -- requirements
Module: cycle_monitor

---
 rtl/cycle_monitor.sv | 132 +++++++++++++
 tb/tb_cycle_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_monitor.sv
// Passive writeback-stage performance monitor: counts cycles, retires, stalls,
// bubbles and retired-instruction classes. Latency: 1 cycle (registered outputs).
// Backpressure: none; it only observes and never drives the pipeline.
//
// Ports:
//   clk_i          - single clock, all state changes on rising edge
//   reset_i        - asynchronous active-low reset, clears every counter
//   valid_w_i      - writeback instruction valid
//   stall_w_i      - writeback stalled this cycle
//   instr_w_i      - instruction word in writeback (only opcode [6:0] used)
//   cycle_cnt_o    - cycles since reset release
//   instret_cnt_o  - retired instructions
//   stall_cnt_o    - stalled cycles
//   bubble_cnt_o   - cycles with neither valid nor stall
//   *_cnt_o        - per-class retired-instruction counts
// All counters wrap modulo 2^CNT_W.
module cycle_monitor #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_w_i,
    input  logic             stall_w_i,
    input  logic [31:0]      instr_w_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] load_cnt_o,
    output logic [CNT_W-1:0] store_cnt_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] jump_cnt_o,
    output logic [CNT_W-1:0] alu_cnt_o,
    output logic [CNT_W-1:0] upper_cnt_o,
    output logic [CNT_W-1:0] system_cnt_o,
    output logic [CNT_W-1:0] other_cnt_o
);

    // Class counter slots
    localparam int CLS_LOAD   = 0;
    localparam int CLS_STORE  = 1;
    localparam int CLS_BRANCH = 2;
    localparam int CLS_JUMP   = 3;
    localparam int CLS_ALU    = 4;
    localparam int CLS_UPPER  = 5;
    localparam int CLS_SYSTEM = 6;
    localparam int CLS_OTHER  = 7;
    localparam int N_CLS      = 8;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic retire;
    logic bubble;
    logic [N_CLS-1:0] cls_hot;

    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] stall_q,   stall_d;
    logic [CNT_W-1:0] bubble_q,  bubble_d;
    logic [CNT_W-1:0] cls_q [N_CLS];
    logic [CNT_W-1:0] cls_d [N_CLS];

    // Visible for hierarchical reads by benches.
    logic [CNT_W-1:0] cycle_cnt;

    // retire, stall and bubble partition every cycle.
    assign retire = valid_w_i & ~stall_w_i;
    assign bubble = ~valid_w_i & ~stall_w_i;

    // Opcode is only looked at when retiring, so an undefined instruction
    // word on idle/stalled cycles can never leak into a class counter.
    always_comb begin
        cls_hot = '0;
        if (retire) begin
            case (instr_w_i[6:0])
                7'b0000011:             cls_hot[CLS_LOAD]   = 1'b1;
                7'b0100011:             cls_hot[CLS_STORE]  = 1'b1;
                7'b1100011:             cls_hot[CLS_BRANCH] = 1'b1;
                7'b1101111, 7'b1100111: cls_hot[CLS_JUMP]   = 1'b1;
                7'b0010011, 7'b0110011: cls_hot[CLS_ALU]    = 1'b1;
                7'b0110111, 7'b0010111: cls_hot[CLS_UPPER]  = 1'b1;
                7'b1110011:             cls_hot[CLS_SYSTEM] = 1'b1;
                default:                cls_hot[CLS_OTHER]  = 1'b1;
            endcase
        end
    end

    always_comb begin
        cycle_d   = cycle_q + ONE;
        instret_d = retire    ? instret_q + ONE : instret_q;
        stall_d   = stall_w_i ? stall_q + ONE   : stall_q;
        bubble_d  = bubble    ? bubble_q + ONE  : bubble_q;
        for (int i = 0; i < N_CLS; i++) begin
            cls_d[i] = cls_hot[i] ? cls_q[i] + ONE : cls_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
            bubble_q  <= '0;
            for (int i = 0; i < N_CLS; i++) begin
                cls_q[i] <= '0;
            end
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
            for (int i = 0; i < N_CLS; i++) begin
                cls_q[i] <= cls_d[i];
            end
        end
    end

    assign cycle_cnt     = cycle_q;
    assign cycle_cnt_o   = cycle_cnt;
    assign instret_cnt_o = instret_q;
    assign stall_cnt_o   = stall_q;
    assign bubble_cnt_o  = bubble_q;
    assign load_cnt_o    = cls_q[CLS_LOAD];
    assign store_cnt_o   = cls_q[CLS_STORE];
    assign branch_cnt_o  = cls_q[CLS_BRANCH];
    assign jump_cnt_o    = cls_q[CLS_JUMP];
    assign alu_cnt_o     = cls_q[CLS_ALU];
    assign upper_cnt_o   = cls_q[CLS_UPPER];
    assign system_cnt_o  = cls_q[CLS_SYSTEM];
    assign other_cnt_o   = cls_q[CLS_OTHER];

endmodule

// File: tb/tb_cycle_monitor.sv
// Directed bench for cycle_monitor: a 64-bit instance for function checks and
// a 4-bit instance sharing the same stimulus for wrap-around checks.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cycle_monitor;

    logic        clk_i;
    logic        reset_i;
    logic        valid_w_i;
    logic        stall_w_i;
    logic [31:0] instr_w_i;

    logic [63:0] cyc, ins, stl, bub, ld, st, br, jp, al, up, sy, ot;
    logic [3:0]  s_cyc, s_ins, s_stl, s_bub, s_ld, s_st, s_br, s_jp, s_al, s_up, s_sy, s_ot;

    int n_chk = 0;
    int n_bad = 0;

    cycle_monitor #(.CNT_W(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_w_i(valid_w_i),
        .stall_w_i(stall_w_i), .instr_w_i(instr_w_i),
        .cycle_cnt_o(cyc), .instret_cnt_o(ins), .stall_cnt_o(stl),
        .bubble_cnt_o(bub), .load_cnt_o(ld), .store_cnt_o(st),
        .branch_cnt_o(br), .jump_cnt_o(jp), .alu_cnt_o(al),
        .upper_cnt_o(up), .system_cnt_o(sy), .other_cnt_o(ot)
    );

    cycle_monitor #(.CNT_W(4)) dut_small (
        .clk_i(clk_i), .reset_i(reset_i), .valid_w_i(valid_w_i),
        .stall_w_i(stall_w_i), .instr_w_i(instr_w_i),
        .cycle_cnt_o(s_cyc), .instret_cnt_o(s_ins), .stall_cnt_o(s_stl),
        .bubble_cnt_o(s_bub), .load_cnt_o(s_ld), .store_cnt_o(s_st),
        .branch_cnt_o(s_br), .jump_cnt_o(s_jp), .alu_cnt_o(s_al),
        .upper_cnt_o(s_up), .system_cnt_o(s_sy), .other_cnt_o(s_ot)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_cyc,
                             input logic [63:0] e_ins, input logic [63:0] e_stl,
                             input logic [63:0] e_bub);
        chk({tag, "_cycle"},   cyc, e_cyc);
        chk({tag, "_instret"}, ins, e_ins);
        chk({tag, "_stall"},   stl, e_stl);
        chk({tag, "_bubble"},  bub, e_bub);
    endtask

    task automatic check_classes(input string tag, input logic [63:0] e [8]);
        chk({tag, "_load"},   ld, e[0]);
        chk({tag, "_store"},  st, e[1]);
        chk({tag, "_branch"}, br, e[2]);
        chk({tag, "_jump"},   jp, e[3]);
        chk({tag, "_alu"},    al, e[4]);
        chk({tag, "_upper"},  up, e[5]);
        chk({tag, "_system"}, sy, e[6]);
        chk({tag, "_other"},  ot, e[7]);
    endtask

    // Hold reset low for two edges, then release between edges.
    task automatic do_reset();
        reset_i = 1'b0;
        valid_w_i = 1'b0;
        stall_w_i = 1'b0;
        instr_w_i = 32'h0;
        step(2);
        reset_i = 1'b1;
    endtask

    // Reference classification: slot order load,store,branch,jump,alu,upper,system,other
    function automatic int ref_class(input logic [6:0] op);
        if (op == 7'h03) return 0;
        if (op == 7'h23) return 1;
        if (op == 7'h63) return 2;
        if (op == 7'h6F || op == 7'h67) return 3;
        if (op == 7'h13 || op == 7'h33) return 4;
        if (op == 7'h37 || op == 7'h17) return 5;
        if (op == 7'h73) return 6;
        return 7;
    endfunction

    logic [63:0] zeros [8];
    logic [63:0] ones  [8];
    logic [63:0] exp_cls [8];
    logic [31:0] prog [7];
    logic [6:0]  ops [12];

    initial begin
        logic [63:0] e_ins, e_stl, e_bub, sum;
        int r;

        for (int i = 0; i < 8; i++) begin
            zeros[i] = 64'd0;
            ones[i]  = (i == 7) ? 64'd0 : 64'd1;
        end
        prog[0] = 32'h00500093; // addi
        prog[1] = 32'h0000A103; // lw
        prog[2] = 32'h0020A023; // sw
        prog[3] = 32'h00208463; // beq
        prog[4] = 32'h008000EF; // jal
        prog[5] = 32'h000010B7; // lui
        prog[6] = 32'h34009073; // csrrw
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h63; ops[3] = 7'h6F;
        ops[4] = 7'h67; ops[5] = 7'h13; ops[6] = 7'h33; ops[7] = 7'h37;
        ops[8] = 7'h17; ops[9] = 7'h73; ops[10] = 7'h0F; ops[11] = 7'h7F;

        // Reset state and idle counting.
        do_reset();
        check_all("rst", 64'd0, 64'd0, 64'd0, 64'd0);
        check_classes("rst", zeros);
        step(10);
        check_all("idle10", 64'd10, 64'd0, 64'd0, 64'd10);
        check_classes("idle10", zeros);
        chk("idle10_hier", dut.cycle_cnt, 64'd10);

        // One of each class on consecutive cycles.
        do_reset();
        valid_w_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instr_w_i = prog[i];
            step(1);
            if (i == 0) chk("mix_lat1_instret", ins, 64'd1);
        end
        valid_w_i = 1'b0;
        check_all("mix", 64'd7, 64'd7, 64'd0, 64'd0);
        check_classes("mix", ones);

        // Stalled lw never retires.
        do_reset();
        valid_w_i = 1'b1;
        stall_w_i = 1'b1;
        instr_w_i = 32'h0000A103;
        step(5);
        check_all("stall", 64'd5, 64'd0, 64'd5, 64'd0);
        chk("stall_load", ld, 64'd0);
        // Stall without valid still counts as stall.
        valid_w_i = 1'b0;
        step(2);
        chk("stall_novalid", stl, 64'd7);
        // Undefined instruction word while idle is ignored.
        stall_w_i = 1'b0;
        instr_w_i = 'x;
        step(3);
        chk("xinstr_other", ot, 64'd0);
        chk("xinstr_bubble", bub, 64'd3);
        instr_w_i = 32'h0;

        // Asynchronous reset in mid-run.
        do_reset();
        valid_w_i = 1'b1;
        instr_w_i = 32'h00500093;
        step(20);
        chk("pre_async_cycle", cyc, 64'd20);
        chk("pre_async_alu", al, 64'd20);
        reset_i = 1'b0;
        #1;
        check_all("async", 64'd0, 64'd0, 64'd0, 64'd0);
        chk("async_alu", al, 64'd0);
        step(3);
        chk("hold_cycle", cyc, 64'd0);
        chk("hold_alu", al, 64'd0);
        reset_i = 1'b1;
        step(1);
        chk("restart_cycle", cyc, 64'd1);
        chk("restart_alu", al, 64'd1);
        valid_w_i = 1'b0;

        // Wrap on the 4-bit instance.
        do_reset();
        step(17);
        chk("wrap_cycle", 64'(s_cyc), 64'd1);
        chk("wrap_bubble", 64'(s_bub), 64'd1);
        chk("wrap_wide_cycle", cyc, 64'd17);

        // Random mix checked against a reference count.
        do_reset();
        e_ins = 0; e_stl = 0; e_bub = 0;
        for (int i = 0; i < 8; i++) exp_cls[i] = 64'd0;
        for (int c = 0; c < 1000; c++) begin
            valid_w_i = 1'($urandom_range(0, 1));
            stall_w_i = ($urandom_range(0, 3) == 0);
            instr_w_i = {$urandom()} & 32'hFFFF_FF80;
            instr_w_i[6:0] = ops[$urandom_range(0, 11)];
            if (stall_w_i) e_stl++;
            else if (valid_w_i) begin
                e_ins++;
                r = ref_class(instr_w_i[6:0]);
                exp_cls[r]++;
            end else e_bub++;
            step(1);
        end
        valid_w_i = 1'b0;
        stall_w_i = 1'b0;
        check_all("rand", 64'd1000, e_ins, e_stl, e_bub);
        chk("rand_partition", ins + stl + bub, 64'd1000);
        check_classes("rand", exp_cls);
        sum = ld + st + br + jp + al + up + sy + ot;
        chk("rand_class_sum", sum, ins);
        chk("rand_small_cycle", 64'(s_cyc), 64'(1000 % 16));
        chk("rand_small_instret", 64'(s_ins), e_ins % 16);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
